// File: rtl/float_to_fixed.sv
// float_to_fixed: iterative IEEE single to 32-bit fixed converter, trunc(value * 2^-scale),
// one logical right shift of the mantissa per clock.
module float_to_fixed #(
   parameter int BIAS = 127
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] float_in,
   input  logic [7:0]  scale_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] fixed_out,
   output logic        ovf,
   output logic        invalid
);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t      state_q, state_d;
   logic        sign_q, sign_d;
   logic [31:0] mag_q, mag_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        sp_q, sp_d, spz_q, spz_d, spo_q, spo_d, spi_q, spi_d;
   logic [31:0] fix_q, fix_d;
   logic        ovf_q, ovf_d, inv_q, inv_d, done_q, done_d;
   logic [7:0]  ex;
   logic [22:0] fr;
   logic [9:0]  e;
   logic        exp_z, exp_m, nan, under, in_rng, exact;
   assign ex     = float_in[30:23];
   assign fr     = float_in[22:0];
   assign e      = {2'b0, ex} - 10'(BIAS) - {{2{scale_in[7]}}, scale_in};
   assign exp_z  = ex == 8'd0;
   assign exp_m  = ex == 8'hFF;
   assign nan    = exp_m && fr != 23'd0;
   assign under  = exp_z || (!exp_m && e[9]);
   assign in_rng = !exp_z && !exp_m && !e[9] && e <= 10'd30;
   // -2^31 is representable, so it saturates to the same value without flagging overflow
   assign exact  = !exp_m && float_in[31] && e == 10'd31 && fr == 23'd0;
   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      mag_d   = mag_q;
      cnt_d   = cnt_q;
      sp_d    = sp_q;
      spz_d   = spz_q;
      spo_d   = spo_q;
      spi_d   = spi_q;
      fix_d   = fix_q;
      ovf_d   = ovf_q;
      inv_d   = inv_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         if (start) begin
            state_d = SHIFT;
            sign_d  = float_in[31];
            mag_d   = {1'b1, fr, 8'b0};
            cnt_d   = in_rng ? 5'(10'd31 - e) : 5'd0;
            sp_d    = !in_rng;
            spz_d   = exp_z || nan || under;
            spo_d   = !(exp_z || nan || under || exact);
            spi_d   = nan;
         end
      end else if (cnt_q != 5'd0) begin
         mag_d = mag_q >> 1;
         cnt_d = cnt_q - 5'd1;
      end else begin
         state_d = IDLE;
         done_d  = 1'b1;
         fix_d   = !sp_q ? (sign_q ? ~mag_q + 32'd1 : mag_q) :
                   spz_q ? 32'd0 : (sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF);
         ovf_d   = sp_q && spo_q;
         inv_d   = sp_q && spi_q;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sign_q  <= 1'b0;
         mag_q   <= '0;
         cnt_q   <= '0;
         sp_q    <= 1'b0;
         spz_q   <= 1'b0;
         spo_q   <= 1'b0;
         spi_q   <= 1'b0;
         fix_q   <= '0;
         ovf_q   <= 1'b0;
         inv_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         mag_q   <= mag_d;
         cnt_q   <= cnt_d;
         sp_q    <= sp_d;
         spz_q   <= spz_d;
         spo_q   <= spo_d;
         spi_q   <= spi_d;
         fix_q   <= fix_d;
         ovf_q   <= ovf_d;
         inv_q   <= inv_d;
         done_q  <= done_d;
      end
   end
   assign busy      = state_q == SHIFT;
   assign done      = done_q;
   assign fixed_out = fix_q;
   assign ovf       = ovf_q;
   assign invalid   = inv_q;
endmodule

// File: tb/tb_float_to_fixed.sv
// tb_float_to_fixed: directed vector table plus hand sequences for busy-ignore,
// back-to-back start and mid-conversion reset.
module tb_float_to_fixed;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] float_in = '0;
   logic [7:0]  scale_in = '0;
   logic        busy, done, ovf, invalid;
   logic [31:0] fixed_out;
   int n_chk = 0;
   int n_fail = 0;
   float_to_fixed dut (
      .clk(clk), .rst(rst), .start(start), .float_in(float_in), .scale_in(scale_in),
      .busy(busy), .done(done), .fixed_out(fixed_out), .ovf(ovf), .invalid(invalid)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [31:0] f;
      logic [7:0]  s;
      logic [31:0] x;
      logic        o;
      logic        iv;
      int          k;
   } vec_t;
   vec_t v[16];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         lat = i;
         if (done) break;
      end
      if (!done) lat = 99;
   endtask
   task automatic run(input logic [31:0] f, input logic [7:0] s, output int lat);
      @(negedge clk);
      float_in = f;
      scale_in = s;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat);
   endtask
   initial begin
      int lat;
      bit seen;
      v[0]  = '{32'h3F80_0000, 8'h00, 32'h0000_0001, 1'b0, 1'b0, 31};
      v[1]  = '{32'hC020_0000, 8'hFE, 32'hFFFF_FFF6, 1'b0, 1'b0, 28};
      v[2]  = '{32'h3F40_0000, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 0};
      v[3]  = '{32'h8000_0000, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 0};
      v[4]  = '{32'h4F00_0000, 8'h00, 32'h7FFF_FFFF, 1'b1, 1'b0, 0};
      v[5]  = '{32'hCF00_0000, 8'h00, 32'h8000_0000, 1'b0, 1'b0, 0};
      v[6]  = '{32'hFF80_0000, 8'h00, 32'h8000_0000, 1'b1, 1'b0, 0};
      v[7]  = '{32'h7FC0_0000, 8'h00, 32'h0000_0000, 1'b0, 1'b1, 0};
      v[8]  = '{32'h7F80_0000, 8'h00, 32'h7FFF_FFFF, 1'b1, 1'b0, 0};
      v[9]  = '{32'h4EFF_FFFF, 8'h00, 32'h7FFF_FF80, 1'b0, 1'b0, 1};
      v[10] = '{32'hCF00_0001, 8'h00, 32'h8000_0000, 1'b1, 1'b0, 0};
      v[11] = '{32'h3F80_0000, 8'h01, 32'h0000_0000, 1'b0, 1'b0, 0};
      v[12] = '{32'h3F80_0000, 8'h80, 32'h7FFF_FFFF, 1'b1, 1'b0, 0};
      v[13] = '{32'h4049_0FDB, 8'hF0, 32'h0003_243F, 1'b0, 1'b0, 14};
      v[14] = '{32'hBFC0_0000, 8'h00, 32'hFFFF_FFFF, 1'b0, 1'b0, 31};
      v[15] = '{32'hBF40_0000, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 0};
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset fixed", fixed_out, 32'd0);
      chk("reset flags", {30'd0, ovf, invalid}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         run(v[i].f, v[i].s, lat);
         chk($sformatf("vec%0d fixed", i), fixed_out, v[i].x);
         chk($sformatf("vec%0d ovf", i), {31'd0, ovf}, {31'd0, v[i].o});
         chk($sformatf("vec%0d invalid", i), {31'd0, invalid}, {31'd0, v[i].iv});
         chk($sformatf("vec%0d latency", i), lat, v[i].k + 1);
      end
      // start pulsed while busy with a different operand must be ignored
      @(negedge clk);
      float_in = 32'h3F80_0000;
      scale_in = 8'h00;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 99;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (i == 3) begin
            start    = 1'b1;
            float_in = 32'h7F80_0000;
         end
         if (i == 4) start = 1'b0;
         if (done) begin
            lat = i;
            break;
         end
      end
      chk("busy-ignore latency", lat, 32);
      chk("busy-ignore fixed", fixed_out, 32'h0000_0001);
      chk("busy-ignore ovf", {31'd0, ovf}, 32'd0);
      // start held across the done cycle starts the next conversion at once
      @(negedge clk);
      float_in = 32'h4000_0000;
      scale_in = 8'h00;
      start    = 1'b1;
      @(posedge clk);
      #1;
      float_in = 32'hC020_0000;
      scale_in = 8'hFE;
      wait_done(lat);
      chk("b2b first latency", lat, 31);
      chk("b2b first fixed", fixed_out, 32'h0000_0002);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b accepted busy", {31'd0, busy}, 32'd1);
      chk("b2b done low", {31'd0, done}, 32'd0);
      wait_done(lat);
      chk("b2b second latency", lat, 29);
      chk("b2b second fixed", fixed_out, 32'hFFFF_FFF6);
      // reset in the middle of a long conversion aborts it
      @(negedge clk);
      float_in = 32'h3F80_0000;
      scale_in = 8'h00;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort done", {31'd0, done}, 32'd0);
      chk("abort fixed", fixed_out, 32'd0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      chk("abort no done", {31'd0, seen}, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
